// File: rtl/mips_core.sv
// mips_core: single-cycle 32-bit MIPS integer core with PC, register file, decoder, ALU and next-PC logic.
// Optional feature macro: MIPS_LINK_JUMPS_EN adds jal/jr; without it both decode as nop.

module mips_regfile #(
  parameter int N         = 32,
  parameter int RegInBits = 5
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [RegInBits-1:0] ra1,
  input  logic [RegInBits-1:0] ra2,
  input  logic [RegInBits-1:0] wa,
  input  logic [N-1:0]         wd,
  output logic [N-1:0]         rd1,
  output logic [N-1:0]         rd2
);

  logic [N-1:0] registers [0:(2**RegInBits)-1];

  // No reset: contents survive reset and may be preloaded; r0 is never written.
  always_ff @(posedge clk) begin
    if (we && (wa != '0)) begin
      registers[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : registers[ra1];
  assign rd2 = (ra2 == '0) ? '0 : registers[ra2];

endmodule

module mips_core #(
  parameter int N         = 32,
  parameter int Pb        = 8,
  parameter int dmAddB    = 5,
  parameter int RegInBits = 5,
  parameter int saBits    = 5,
  parameter int ImmBits   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      ins,
  input  logic [N-1:0]      dm_q,
  output logic [Pb-1:0]     nxt_pc,
  output logic              dm_we,
  output logic              dm_re,
  output logic [dmAddB-1:0] dm_ad,
  output logic [N-1:0]      dm_d
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

`ifdef MIPS_LINK_JUMPS_EN
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
`endif

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL
  } alu_op_e;

  logic [5:0]           op;
  logic [5:0]           funct;
  logic [RegInBits-1:0] rs_a;
  logic [RegInBits-1:0] rt_a;
  logic [RegInBits-1:0] rd_a;
  logic [saBits-1:0]    sa;
  logic [ImmBits-1:0]   imm;

  assign op    = ins[31:26];
  assign rs_a  = ins[25:21];
  assign rt_a  = ins[20:16];
  assign rd_a  = ins[15:11];
  assign sa    = ins[10:6];
  assign funct = ins[5:0];
  assign imm   = ins[ImmBits-1:0];

  logic    reg_we;
  logic    wa_sel_rt;
  logic    use_imm;
  logic    imm_zext;
  logic    mem_rd;
  logic    mem_wr;
  logic    br_eq;
  logic    br_ne;
  logic    jump;
  logic    jump_reg;
  logic    link;
  alu_op_e alu_op;

  always_comb begin
    reg_we    = 1'b0;
    wa_sel_rt = 1'b0;
    use_imm   = 1'b0;
    imm_zext  = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    br_eq     = 1'b0;
    br_ne     = 1'b0;
    jump      = 1'b0;
    jump_reg  = 1'b0;
    link      = 1'b0;
    alu_op    = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin reg_we = 1'b1; alu_op = ALU_ADD; end
          FN_SUB: begin reg_we = 1'b1; alu_op = ALU_SUB; end
          FN_AND: begin reg_we = 1'b1; alu_op = ALU_AND; end
          FN_OR:  begin reg_we = 1'b1; alu_op = ALU_OR;  end
          FN_SLT: begin reg_we = 1'b1; alu_op = ALU_SLT; end
          FN_SLL: begin reg_we = 1'b1; alu_op = ALU_SLL; end
          FN_SRL: begin reg_we = 1'b1; alu_op = ALU_SRL; end
`ifdef MIPS_LINK_JUMPS_EN
          FN_JR:  jump_reg = 1'b1;
`endif
          default: ;
        endcase
      end
      OP_ADDI: begin reg_we = 1'b1; wa_sel_rt = 1'b1; use_imm = 1'b1; end
      OP_SLTI: begin reg_we = 1'b1; wa_sel_rt = 1'b1; use_imm = 1'b1; alu_op = ALU_SLT; end
      OP_ANDI: begin
        reg_we = 1'b1; wa_sel_rt = 1'b1; use_imm = 1'b1; imm_zext = 1'b1; alu_op = ALU_AND;
      end
      OP_ORI: begin
        reg_we = 1'b1; wa_sel_rt = 1'b1; use_imm = 1'b1; imm_zext = 1'b1; alu_op = ALU_OR;
      end
      OP_LW:  begin reg_we = 1'b1; wa_sel_rt = 1'b1; use_imm = 1'b1; mem_rd = 1'b1; end
      OP_SW:  begin use_imm = 1'b1; mem_wr = 1'b1; end
      OP_BEQ: br_eq = 1'b1;
      OP_BNE: br_ne = 1'b1;
      OP_J:   jump = 1'b1;
`ifdef MIPS_LINK_JUMPS_EN
      OP_JAL: begin jump = 1'b1; link = 1'b1; reg_we = 1'b1; end
`endif
      default: ;
    endcase
  end

  logic [N-1:0]         rs_val;
  logic [N-1:0]         rt_val;
  logic [N-1:0]         wb_data;
  logic [RegInBits-1:0] wa;

  assign wa = link ? '1 : (wa_sel_rt ? rt_a : rd_a);

  mips_regfile #(
    .N         (N),
    .RegInBits (RegInBits)
  ) rf (
    .clk (clk),
    .we  (reg_we & rst),
    .ra1 (rs_a),
    .ra2 (rt_a),
    .wa  (wa),
    .wd  (wb_data),
    .rd1 (rs_val),
    .rd2 (rt_val)
  );

  logic [N-1:0] imm_ext;
  logic [N-1:0] alu_b;
  logic [N-1:0] alu_result;

  assign imm_ext = imm_zext ? {{(N-ImmBits){1'b0}}, imm}
                            : {{(N-ImmBits){imm[ImmBits-1]}}, imm};
  assign alu_b   = use_imm ? imm_ext : rt_val;

  // Shifts act on rt (alu_b for R-type) by the instruction's sa field.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD: alu_result = rs_val + alu_b;
      ALU_SUB: alu_result = rs_val - alu_b;
      ALU_AND: alu_result = rs_val & alu_b;
      ALU_OR:  alu_result = rs_val | alu_b;
      ALU_SLT: alu_result = {{(N-1){1'b0}}, ($signed(rs_val) < $signed(alu_b))};
      ALU_SLL: alu_result = alu_b << sa;
      ALU_SRL: alu_result = alu_b >> sa;
      default: alu_result = '0;
    endcase
  end

  logic [Pb-1:0] pc_q;
  logic [Pb-1:0] pc_d;
  logic [Pb-1:0] pc_plus1;
  logic [Pb-1:0] branch_target;
  logic          operands_equal;

  assign pc_plus1       = pc_q + 1'b1;
  assign branch_target  = pc_plus1 + imm[Pb-1:0];
  assign operands_equal = (rs_val == rt_val);

  always_comb begin
    if (mem_rd) begin
      wb_data = dm_q;
    end else if (link) begin
      wb_data = {{(N-Pb){1'b0}}, pc_plus1};
    end else begin
      wb_data = alu_result;
    end
  end

  always_comb begin
    pc_d = pc_plus1;
    if (jump) begin
      pc_d = ins[Pb-1:0];
    end else if (jump_reg) begin
      pc_d = rs_val[Pb-1:0];
    end else if ((br_eq && operands_equal) || (br_ne && !operands_equal)) begin
      pc_d = branch_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign nxt_pc = pc_q;
  assign dm_we  = mem_wr & rst;
  assign dm_re  = mem_rd & rst;
  assign dm_ad  = alu_result[dmAddB+1:2];
  assign dm_d   = rt_val;

endmodule

// File: tb/tb_mips_core.sv
// tb_mips_core: scoreboard bench for mips_core; drives one instruction per cycle and checks queued expectations.
// Exercises jal/jr when MIPS_LINK_JUMPS_EN is defined, otherwise checks they behave as nop.

module tb_mips_core;

  logic        clk;
  logic        rst;
  logic [31:0] ins;
  logic [31:0] dm_q;
  logic [7:0]  nxt_pc;
  logic        dm_we;
  logic        dm_re;
  logic [4:0]  dm_ad;
  logic [31:0] dm_d;

  logic [31:0] ram [0:31];

  int checks = 0;
  int errors = 0;

  localparam int K_PC  = 0;
  localparam int K_REG = 1;
  localparam int K_RAM = 2;
  localparam int K_WE  = 3;
  localparam int K_RE  = 4;
  localparam int K_AD  = 5;
  localparam int K_DD  = 6;

  typedef struct {
    string       tag;
    int          phase;
    int          kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t sbQ[$];

  mips_core dut (
    .clk    (clk),
    .rst    (rst),
    .ins    (ins),
    .dm_q   (dm_q),
    .nxt_pc (nxt_pc),
    .dm_we  (dm_we),
    .dm_re  (dm_re),
    .dm_ad  (dm_ad),
    .dm_d   (dm_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign dm_q = ram[dm_ad];

  always @(posedge clk) begin
    if (dm_we) begin
      ram[dm_ad] <= dm_d;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  function automatic logic [31:0] observe(input int kind, input int idx);
    logic [4:0] i5;
    i5 = idx[4:0];
    case (kind)
      K_PC:    return {24'd0, nxt_pc};
      K_REG:   return dut.rf.registers[i5];
      K_RAM:   return ram[i5];
      K_WE:    return {31'd0, dm_we};
      K_RE:    return {31'd0, dm_re};
      K_AD:    return {27'd0, dm_ad};
      K_DD:    return dm_d;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic expectPre(input string tag, input int kind, input int idx, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.phase = 0; e.kind = kind; e.idx = idx; e.val = val;
    sbQ.push_back(e);
  endtask

  task automatic expectPost(input string tag, input int kind, input int idx, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.phase = 1; e.kind = kind; e.idx = idx; e.val = val;
    sbQ.push_back(e);
  endtask

  task automatic drain(input int phase);
    exp_t e;
    while (sbQ.size() > 0 && sbQ[0].phase == phase) begin
      e = sbQ.pop_front();
      checkOutput(e.tag, observe(e.kind, e.idx), e.val);
    end
  endtask

  // Called just after a rising edge: present one instruction, check combinational outputs, clock it.
  task automatic applyStimulus(input logic [31:0] instr, input logic [7:0] expPc);
    expectPost("pc", K_PC, 0, {24'd0, expPc});
    ins = instr;
    #1;
    drain(0);
    @(posedge clk);
    #1;
    drain(1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 32'h0;
    ram[0] = 32'h0000_00A5;
    ram[1] = 32'h0000_0003;
    ram[3] = 32'h0000_DEAD;

    $display("[TB] power-on reset");
    rst = 1'b0;
    ins = itype(6'h2B, 5'd0, 5'd0, 16'h0000);
    #2;
    expectPre("rst_pc", K_PC, 0, 32'd0);
    expectPre("rst_we", K_WE, 0, 32'd0);
    drain(0);
    @(posedge clk);
    #1;
    expectPre("rst_ram0", K_RAM, 0, 32'h0000_00A5);
    ins = itype(6'h23, 5'd0, 5'd20, 16'h0004);
    #1;
    expectPre("rst_re", K_RE, 0, 32'd0);
    expectPre("rst_pc2", K_PC, 0, 32'd0);
    drain(0);
    @(posedge clk);
    #1;
    ins = 32'h0;
    #2;
    rst = 1'b1;
    #1;
    expectPre("rel_pc", K_PC, 0, 32'd0);
    drain(0);
    @(posedge clk);
    #1;
    expectPre("first_pc", K_PC, 0, 32'd1);
    drain(0);

    $display("[TB] arithmetic and logic");
    expectPost("addi_r3", K_REG, 3, 32'd3);
    applyStimulus(itype(6'h08, 5'd0, 5'd3, 16'h0003), 8'd2);
    expectPost("ori_r4", K_REG, 4, 32'd4);
    applyStimulus(itype(6'h0D, 5'd0, 5'd4, 16'h0004), 8'd3);
    expectPost("add_r18", K_REG, 18, 32'd7);
    applyStimulus(rtype(5'd3, 5'd4, 5'd18, 5'd0, 6'h20), 8'd4);
    expectPost("sub_r19", K_REG, 19, 32'hFFFF_FFFF);
    applyStimulus(rtype(5'd3, 5'd4, 5'd19, 5'd0, 6'h22), 8'd5);
    expectPost("andi_zext", K_REG, 8, 32'h0000_8001);
    applyStimulus(itype(6'h0C, 5'd19, 5'd8, 16'h8001), 8'd6);
    expectPost("addi_sext", K_REG, 9, 32'hFFFF_FFFF);
    applyStimulus(itype(6'h08, 5'd0, 5'd9, 16'hFFFF), 8'd7);
    expectPost("or_r10", K_REG, 10, 32'h0000_8007);
    applyStimulus(rtype(5'd18, 5'd8, 5'd10, 5'd0, 6'h25), 8'd8);
    expectPost("and_r11", K_REG, 11, 32'd7);
    applyStimulus(rtype(5'd19, 5'd18, 5'd11, 5'd0, 6'h24), 8'd9);
    expectPost("sll_r12", K_REG, 12, 32'h0000_0030);
    applyStimulus(rtype(5'd0, 5'd3, 5'd12, 5'd4, 6'h00), 8'd10);
    expectPost("srl_r13", K_REG, 13, 32'h0000_000F);
    applyStimulus(rtype(5'd0, 5'd19, 5'd13, 5'd28, 6'h02), 8'd11);
    expectPost("slt_r21", K_REG, 21, 32'd1);
    applyStimulus(rtype(5'd19, 5'd3, 5'd21, 5'd0, 6'h2A), 8'd12);
    expectPost("slti_r14", K_REG, 14, 32'd0);
    applyStimulus(itype(6'h0A, 5'd3, 5'd14, 16'hFFFF), 8'd13);
    applyStimulus(itype(6'h08, 5'd0, 5'd0, 16'h0005), 8'd14);

    $display("[TB] memory access");
    expectPre("sw0_we", K_WE, 0, 32'd1);
    expectPre("sw0_ad", K_AD, 0, 32'd3);
    expectPre("r0_zero", K_DD, 0, 32'd0);
    expectPost("sw0_ram3", K_RAM, 3, 32'd0);
    applyStimulus(itype(6'h2B, 5'd0, 5'd0, 16'h000C), 8'd15);
    expectPre("lw_re", K_RE, 0, 32'd1);
    expectPre("lw_we", K_WE, 0, 32'd0);
    expectPre("lw_ad", K_AD, 0, 32'd1);
    expectPost("lw_r20", K_REG, 20, 32'd3);
    applyStimulus(itype(6'h23, 5'd0, 5'd20, 16'h0004), 8'd16);
    expectPost("addi_r5", K_REG, 5, 32'd5);
    applyStimulus(itype(6'h08, 5'd0, 5'd5, 16'h0005), 8'd17);
    expectPre("sw_we", K_WE, 0, 32'd1);
    expectPre("sw_dd", K_DD, 0, 32'd5);
    expectPre("sw_ad", K_AD, 0, 32'd2);
    expectPost("sw_ram2", K_RAM, 2, 32'd5);
    applyStimulus(itype(6'h2B, 5'd0, 5'd5, 16'h0008), 8'd18);
    expectPre("lw_wrap_ad", K_AD, 0, 32'd1);
    expectPost("lw_wrap_r16", K_REG, 16, 32'd3);
    applyStimulus(itype(6'h23, 5'd0, 5'd16, 16'h0087), 8'd19);
    expectPost("add_wrap", K_REG, 17, 32'd2);
    applyStimulus(rtype(5'd19, 5'd3, 5'd17, 5'd0, 6'h20), 8'd20);
    expectPre("badop_we", K_WE, 0, 32'd0);
    expectPre("badop_re", K_RE, 0, 32'd0);
    expectPost("badop_r18", K_REG, 18, 32'd7);
    applyStimulus(itype(6'h3F, 5'd0, 5'd18, 16'h0000), 8'd21);
    expectPost("badfn_r18", K_REG, 18, 32'd7);
    applyStimulus(rtype(5'd3, 5'd4, 5'd18, 5'd0, 6'h3F), 8'd22);

    $display("[TB] branches and jumps");
    applyStimulus(itype(6'h08, 5'd0, 5'd1, 16'h0001), 8'd23);
    applyStimulus(itype(6'h08, 5'd0, 5'd2, 16'h0001), 8'd24);
    applyStimulus(itype(6'h04, 5'd1, 5'd2, 16'h0002), 8'd27);
    applyStimulus(itype(6'h05, 5'd1, 5'd2, 16'h0002), 8'd28);
    applyStimulus(itype(6'h04, 5'd1, 5'd3, 16'h0002), 8'd29);
    applyStimulus(itype(6'h05, 5'd1, 5'd3, 16'hFFFD), 8'd27);
    applyStimulus(itype(6'h04, 5'd0, 5'd0, 16'hFFE2), 8'd254);
    applyStimulus(32'h0, 8'd255);
    applyStimulus(32'h0, 8'd0);
    applyStimulus(jtype(6'h02, 26'h0000040), 8'd64);
    applyStimulus(jtype(6'h02, 26'h3FFFF05), 8'd5);

    $display("[TB] reset mid-program");
    ins = itype(6'h2B, 5'd0, 5'd0, 16'h0000);
    rst = 1'b0;
    #1;
    expectPre("mid_pc", K_PC, 0, 32'd0);
    expectPre("mid_we", K_WE, 0, 32'd0);
    drain(0);
    ins = itype(6'h08, 5'd0, 5'd18, 16'h0055);
    @(posedge clk);
    #1;
    expectPre("mid_pc_hold", K_PC, 0, 32'd0);
    expectPre("mid_nowrite", K_REG, 18, 32'd7);
    drain(0);
    ins = 32'h0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    expectPre("mid_rel_pc", K_PC, 0, 32'd1);
    drain(0);

    $display("[TB] link jumps");
    expectPost("set_r31", K_REG, 31, 32'h0000_0123);
    applyStimulus(itype(6'h08, 5'd0, 5'd31, 16'h0123), 8'd2);
`ifdef MIPS_LINK_JUMPS_EN
    expectPost("jal_r31", K_REG, 31, 32'd3);
    applyStimulus(jtype(6'h03, 26'h000000A), 8'd10);
    applyStimulus(rtype(5'd31, 5'd0, 5'd0, 5'd0, 6'h08), 8'd3);
`else
    expectPost("jal_nop_r31", K_REG, 31, 32'h0000_0123);
    applyStimulus(jtype(6'h03, 26'h000000A), 8'd3);
    applyStimulus(rtype(5'd31, 5'd0, 5'd0, 5'd0, 6'h08), 8'd4);
`endif

    checkOutput("sb_empty", sbQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
